// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: LSB-first ripple through a single full adder.
// Result, carry-out and overflow are registered once the MSB has been processed.
module serial_addsub #(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [WIDTH:0] A,
    input  logic [WIDTH:0] B,
    input  logic           Sub,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] S,
    output logic           Cout,
    output logic           Ovf
);

    localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q;
    logic [WIDTH:0]  a_q;
    logic [WIDTH:0]  b_q;
    logic [WIDTH-1:0] r_q;
    logic            c_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [WIDTH:0]  s_q;
    logic            cout_q;
    logic            ovf_q;

    logic            sum_d;
    logic            carry_d;
    logic            last_d;
    logic [WIDTH:0]  r_d;

    // Full adder on the current LSBs plus the result word after this bit
    always_comb begin
        sum_d   = a_q[0] ^ b_q[0] ^ c_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        last_d  = (cnt_q == CW'(WIDTH));
        r_d     = {sum_d, r_q};
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        c_q     <= Sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= r_d[WIDTH:1];
                    c_q   <= carry_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        // c_q is the carry into the MSB here
                        s_q     <= r_d;
                        cout_q  <= carry_d;
                        ovf_q   <= c_q ^ carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=3).
// Reference results come from plain integer arithmetic.
module tb_serial_addsub;

    localparam int W = 3;
    typedef logic [W:0] word_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    word_t A;
    word_t B;
    logic  Sub;
    logic  busy;
    logic  done;
    word_t S;
    logic  Cout;
    logic  Ovf;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    pulses = 0;
    word_t last_s = '0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .Sub  (Sub),
        .busy (busy),
        .done (done),
        .S    (S),
        .Cout (Cout),
        .Ovf  (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unsigned sum gives S/Cout; signed sum range gives overflow
    task automatic ref_model(input word_t a, input word_t b, input logic sub,
                             output word_t s, output logic c, output logic o);
        int u;
        int sa;
        int sb;
        int t;
        u  = int'(a) + int'(b) + int'(sub);
        s  = word_t'(u % 16);
        c  = (u >= 16);
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        t  = sa + sb + int'(sub);
        o  = (t > 7) || (t < -8);
    endtask

    task automatic run_op(input word_t a, input word_t b, input logic sub,
                          input bit poke, input string tag);
        word_t es;
        logic  ec;
        logic  eo;
        int    lat;
        int    p0;
        bit    held;
        ref_model(a, b, sub, es, ec, eo);
        @(negedge clk);
        A = a; B = b; Sub = sub; start = 1'b1;
        p0 = pulses;
        @(posedge clk); #1;
        start = 1'b0;
        A = word_t'($urandom); B = word_t'($urandom); Sub = 1'($urandom);
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        lat = 0;
        held = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (poke && k == 1) begin
                start = 1'b1;
                A = word_t'($urandom); B = word_t'($urandom); Sub = ~sub;
            end
            if (poke && k == 2) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (S !== last_s) held = 1'b0;
        end
        chk({tag, "/lat"}, 32'(lat), 32'd4);
        chk({tag, "/hold"}, 32'(held), 32'd1);
        chk({tag, "/S"}, 32'(S), 32'(es));
        chk({tag, "/Cout"}, 32'(Cout), 32'(ec));
        chk({tag, "/Ovf"}, 32'(Ovf), 32'(eo));
        last_s = es;
        @(posedge clk); #1;
        chk({tag, "/done1"}, 32'(done), 32'd0);
        chk({tag, "/idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/pulses"}, 32'(pulses - p0), 32'd1);
        chk({tag, "/nostart"}, 32'(busy), 32'd0);
    endtask

    task automatic mid_reset();
        int p0;
        @(negedge clk);
        A = 4'b0110; B = 4'b0011; Sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst/busy_pre", 32'(busy), 32'd1);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/S", 32'(S), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_s = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst/nodone", 32'(pulses - p0), 32'd0);
        chk("rst/idle", 32'(busy), 32'd0);
        chk("rst/S_kept", 32'(S), 32'd0);
    endtask

    task automatic back_to_back();
        word_t va [3];
        word_t vb [3];
        logic  vs [3];
        int    t [3];
        word_t es;
        logic  ec;
        logic  eo;
        bit    got;
        for (int i = 0; i < 3; i++) begin
            va[i] = word_t'($urandom);
            vb[i] = word_t'($urandom);
            vs[i] = 1'($urandom);
        end
        @(negedge clk);
        A = va[0]; B = vb[0]; Sub = vs[0]; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ref_model(va[i], vb[i], vs[i], es, ec, eo);
            got = 1'b0;
            t[i] = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (done) begin
                    got = 1'b1;
                    t[i] = cyc;
                    break;
                end
            end
            chk("b2b/seen", 32'(got), 32'd1);
            chk("b2b/S", 32'(S), 32'(es));
            chk("b2b/Cout", 32'(Cout), 32'(ec));
            chk("b2b/Ovf", 32'(Ovf), 32'(eo));
            last_s = es;
            if (i < 2) begin
                A = va[i+1]; B = vb[i+1]; Sub = vs[i+1];
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b/gap1", 32'(t[1] - t[0]), 32'd6);
        chk("b2b/gap2", 32'(t[2] - t[1]), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b/idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/S", 32'(S), 32'd0);
        chk("reset/Cout", 32'(Cout), 32'd0);
        chk("reset/Ovf", 32'(Ovf), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle/busy", 32'(busy), 32'd0);

        run_op(4'b0011, 4'b0100, 1'b0, 1'b0, "add");
        chk("add/S_const", 32'(S), 32'h7);
        run_op(4'b0101, 4'b1100, 1'b1, 1'b0, "sub");
        chk("sub/Cout_const", 32'(Cout), 32'h1);
        run_op(4'b0111, 4'b0001, 1'b0, 1'b0, "povf");
        chk("povf/Ovf_const", 32'(Ovf), 32'h1);
        run_op(4'b1000, 4'b1110, 1'b1, 1'b0, "novf");
        chk("novf/S_const", 32'(S), 32'h7);
        run_op(4'b0010, 4'b0101, 1'b0, 1'b1, "poke");

        mid_reset();
        run_op(4'b1001, 4'b0110, 1'b1, 1'b0, "after_rst");

        back_to_back();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    run_op(word_t'(a), word_t'(b), 1'(s), 1'b0, "sweep");
                end
            end
        end

        for (int i = 0; i < 100; i++) begin
            run_op(word_t'($urandom), word_t'($urandom), 1'($urandom),
                   1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
